// File: rtl/rtosunit_mem_pkg.sv
// Shared types and defaults for the RTOS-unit memory port arbiter.
package rtosunit_mem_pkg;

  typedef enum logic {
    CPU = 1'b0,
    CTX = 1'b1
  } src_e;

  typedef struct packed {
    src_e src;
    logic we;
  } trk_entry_t;

  localparam int unsigned TRK_ENTRY_W             = $bits(trk_entry_t);
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;
  localparam int unsigned DEFAULT_STARVE_LIMIT    = 8;

endpackage

// File: rtl/obi_src_fifo.sv
// Response-source tracker: records which port issued each granted request
// so in-order responses can be routed back to their originator.
module obi_src_fifo
  import rtosunit_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [TRK_ENTRY_W-1:0] entry_i,
  input  logic                   pop_i,
  output logic [TRK_ENTRY_W-1:0] head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [TRK_ENTRY_W-1:0] mem_q [DEPTH];
  logic [TRK_ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  always_comb begin
    full_o   = (count_q == CNT_W'(DEPTH));
    empty_o  = (count_q == '0);
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (do_push) begin
      mem_d[wr_ptr_q] = entry_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/obi_ctx_arbiter.sv
// Arbitrates the CPU and RTOS context-unit OBI ports onto one memory port,
// with starvation protection for ctx and in-order response routing.
module obi_ctx_arbiter
  import rtosunit_mem_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT    = DEFAULT_STARVE_LIMIT
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        cpu_req_i,
  output logic        cpu_gnt_o,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_be_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,

  input  logic        ctx_req_i,
  output logic        ctx_gnt_o,
  input  logic        ctx_we_i,
  input  logic [31:0] ctx_addr_i,
  input  logic [31:0] ctx_wdata_i,
  output logic        ctx_rvalid_o,
  output logic [31:0] ctx_rdata_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  src_e                   sel;
  src_e                   sel_q, sel_d;
  logic                   lock_q, lock_d;
  logic [STV_W-1:0]       starve_q, starve_d;
  logic                   handshake;

  trk_entry_t             push_entry;
  trk_entry_t             head;
  logic [TRK_ENTRY_W-1:0] head_raw;
  logic                   trk_full, trk_empty, trk_pop;
  logic [CNT_W-1:0]       trk_count;

  // Request side: selection, mux and grants.
  always_comb begin
    if (lock_q) begin
      sel = sel_q;
    end else if (ctx_req_i && ((starve_q == STV_MAX) || !cpu_req_i)) begin
      sel = CTX;
    end else begin
      sel = CPU;
    end

    // Gated with rst_ni so the request is quiet while reset is held.
    mem_req_o = rst_ni & (cpu_req_i | ctx_req_i) & (trk_count < CNT_MAX);

    if (sel == CTX) begin
      mem_we_o    = ctx_we_i;
      mem_be_o    = 4'hF;
      mem_addr_o  = ctx_addr_i;
      mem_wdata_o = ctx_wdata_i;
    end else begin
      mem_we_o    = cpu_we_i;
      mem_be_o    = cpu_be_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end

    handshake  = mem_req_o & mem_gnt_i;
    cpu_gnt_o  = handshake & (sel == CPU);
    ctx_gnt_o  = handshake & (sel == CTX);
    push_entry = '{src: sel, we: mem_we_o};
  end

  always_comb begin
    lock_d = mem_req_o & ~mem_gnt_i;
    sel_d  = sel;

    if (!ctx_req_i || ctx_gnt_o) begin
      starve_d = '0;
    end else if (starve_q != STV_MAX) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q    <= CPU;
      lock_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      starve_q <= starve_d;
    end
  end

  obi_src_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_trk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .entry_i (push_entry),
    .pop_i   (trk_pop),
    .head_o  (head_raw),
    .full_o  (trk_full),
    .empty_o (trk_empty),
    .count_o (trk_count)
  );

  // Response side: a response with nothing outstanding is dropped.
  always_comb begin
    head         = trk_entry_t'(head_raw);
    trk_pop      = mem_rvalid_i & ~trk_empty;
    cpu_rvalid_o = trk_pop & (head.src == CPU);
    ctx_rvalid_o = trk_pop & (head.src == CTX) & ~head.we;
    cpu_rdata_o  = mem_rdata_i;
    ctx_rdata_o  = mem_rdata_i;
  end

  stray_rvalid_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && trk_empty))
    else $warning("mem_rvalid_i with no outstanding request was dropped");

  push_when_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(handshake && trk_full))
    else $error("grant accepted while response tracker full");

endmodule

// File: tb/tb_obi_ctx_arbiter.sv
// Bench for obi_ctx_arbiter: combinational vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_obi_ctx_arbiter;

  localparam int unsigned MAXO = 4;
  localparam int unsigned LIM  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_i, cpu_gnt_o, cpu_we_i, cpu_rvalid_o;
  logic [3:0]  cpu_be_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        ctx_req_i, ctx_gnt_o, ctx_we_i, ctx_rvalid_o;
  logic [31:0] ctx_addr_i, ctx_wdata_i, ctx_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_ctx_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .STARVE_LIMIT    (LIM)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_req_i    (cpu_req_i),
    .cpu_gnt_o    (cpu_gnt_o),
    .cpu_we_i     (cpu_we_i),
    .cpu_be_i     (cpu_be_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .ctx_req_i    (ctx_req_i),
    .ctx_gnt_o    (ctx_gnt_o),
    .ctx_we_i     (ctx_we_i),
    .ctx_addr_i   (ctx_addr_i),
    .ctx_wdata_i  (ctx_wdata_i),
    .ctx_rvalid_o (ctx_rvalid_o),
    .ctx_rdata_o  (ctx_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  typedef struct {
    string       name;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        ctx_req, ctx_we;
    logic [31:0] ctx_addr, ctx_wdata;
    logic        gnt, rvalid;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    logic        e_cgnt, e_xgnt;
  } vec_t;

  vec_t tbl [8];

  // Reference model state: outstanding sources in issue order.
  bit mq_src [$];
  bit mq_we  [$];
  int m_starve;
  bit m_locked, m_lsrc;
  bit m_req, m_sel, m_we, m_cg, m_xg, m_crv, m_xrv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ctl5();
    return {mem_req_o, cpu_gnt_o, ctx_gnt_o, cpu_rvalid_o, ctx_rvalid_o};
  endfunction

  task automatic check_ctl(input string name, input logic [4:0] exp);
    check(name, 32'(ctl5()), 32'(exp));
  endtask

  task automatic idle_inputs();
    cpu_req_i = 0; cpu_we_i = 0; cpu_be_i = '0; cpu_addr_i = '0; cpu_wdata_i = '0;
    ctx_req_i = 0; ctx_we_i = 0; ctx_addr_i = '0; ctx_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    // Reset held with every input active: outputs must stay quiet.
    rst_n = 0;
    idle_inputs();
    cpu_req_i = 1; ctx_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    #3;
    check_ctl("reset_outputs", 5'b00000);
    check("reset_count", 32'(dut.trk_count), 32'd0);
    reset_dut();

    // Combinational vectors from the idle post-reset state.
    tbl[0] = '{"idle",        0,0,4'h0,32'h0,   32'h0,  0,0,32'h0,   32'h0,  0,0, 0,0,4'h0,32'h0,   32'h0,  0,0};
    tbl[1] = '{"cpu_rd",      1,0,4'h5,32'h1000,32'h11, 0,0,32'h0,   32'h0,  1,0, 1,0,4'h5,32'h1000,32'h11, 1,0};
    tbl[2] = '{"ctx_wr",      0,0,4'h3,32'h0,   32'h0,  1,1,32'h2000,32'h22, 1,0, 1,1,4'hF,32'h2000,32'h22, 0,1};
    tbl[3] = '{"both_gnt",    1,1,4'hC,32'h3000,32'h33, 1,0,32'h3004,32'h34, 1,0, 1,1,4'hC,32'h3000,32'h33, 1,0};
    tbl[4] = '{"both_wait",   1,0,4'hF,32'h4000,32'h44, 1,1,32'h4004,32'h45, 0,0, 1,0,4'hF,32'h4000,32'h44, 0,0};
    tbl[5] = '{"ctx_rd_wait", 0,1,4'h0,32'h0,   32'h0,  1,0,32'h5000,32'h55, 0,0, 1,0,4'hF,32'h5000,32'h55, 0,0};
    tbl[6] = '{"rv_empty",    0,0,4'h0,32'h0,   32'h0,  0,0,32'h0,   32'h0,  0,1, 0,0,4'h0,32'h0,   32'h0,  0,0};
    tbl[7] = '{"cpu_wr_rv",   1,1,4'h1,32'h7000,32'h77, 0,0,32'h0,   32'h0,  1,1, 1,1,4'h1,32'h7000,32'h77, 1,0};

    for (int i = 0; i < 8; i++) begin
      cpu_req_i = tbl[i].cpu_req; cpu_we_i = tbl[i].cpu_we; cpu_be_i = tbl[i].cpu_be;
      cpu_addr_i = tbl[i].cpu_addr; cpu_wdata_i = tbl[i].cpu_wdata;
      ctx_req_i = tbl[i].ctx_req; ctx_we_i = tbl[i].ctx_we;
      ctx_addr_i = tbl[i].ctx_addr; ctx_wdata_i = tbl[i].ctx_wdata;
      mem_gnt_i = tbl[i].gnt; mem_rvalid_i = tbl[i].rvalid;
      #2;
      check({"tbl_ctl_", tbl[i].name}, 32'(ctl5()),
            32'({tbl[i].e_req, tbl[i].e_cgnt, tbl[i].e_xgnt, 2'b00}));
      check({"tbl_we_", tbl[i].name}, 32'(mem_we_o), 32'(tbl[i].e_we));
      if (tbl[i].e_req) begin
        check({"tbl_addr_", tbl[i].name}, mem_addr_o, tbl[i].e_addr);
        check({"tbl_be_", tbl[i].name}, 32'(mem_be_o), 32'(tbl[i].e_be));
        check({"tbl_wdata_", tbl[i].name}, mem_wdata_o, tbl[i].e_wdata);
      end
      // Back to idle before the edge so the tracker stays empty.
      idle_inputs();
      tick();
    end

    // Simultaneous CPU/ctx reads; responses routed in issue order.
    reset_dut();
    cpu_req_i = 1; cpu_addr_i = 32'h100; ctx_req_i = 1; ctx_addr_i = 32'h200; mem_gnt_i = 1;
    #2;
    check_ctl("dual_c1", 5'b11000);
    check("dual_addr1", mem_addr_o, 32'h100);
    tick();
    cpu_req_i = 0;
    #2;
    check_ctl("dual_c2", 5'b10100);
    check("dual_addr2", mem_addr_o, 32'h200);
    tick();
    ctx_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA;
    #2;
    check_ctl("dual_rsp_a", 5'b00010);
    check("dual_rdata_a", cpu_rdata_o, 32'hA);
    tick();
    mem_rdata_i = 32'hB;
    #2;
    check_ctl("dual_rsp_b", 5'b00001);
    check("dual_rdata_b", ctx_rdata_o, 32'hB);
    tick();

    // Starvation: ctx wins on cycle 9, then CPU regains priority.
    reset_dut();
    cpu_req_i = 1; cpu_addr_i = 32'h600; ctx_req_i = 1; ctx_addr_i = 32'h700; mem_gnt_i = 1;
    for (int n = 1; n <= 12; n++) begin
      mem_rvalid_i = (n >= 2);
      #2;
      check_ctl($sformatf("starve_n%0d", n),
                {1'b1, n != 9, n == 9, (n >= 2) && (n != 10), n == 10});
      tick();
    end

    // Full tracker blocks requests, including on the cycle of a pop.
    reset_dut();
    cpu_req_i = 1; cpu_addr_i = 32'h800; mem_gnt_i = 1;
    for (int n = 1; n <= 8; n++) begin
      mem_rvalid_i = (n == 7);
      #2;
      check_ctl($sformatf("full_n%0d", n),
                (n <= 4 || n == 8) ? 5'b11000 : ((n == 7) ? 5'b00010 : 5'b00000));
      if (n == 5) check("full_count", 32'(dut.trk_count), 32'd4);
      tick();
    end

    // Ctx write response is consumed without an output pulse.
    reset_dut();
    ctx_req_i = 1; ctx_we_i = 1; ctx_addr_i = 32'h300; mem_gnt_i = 1;
    #2;
    check_ctl("ctxwr_gnt", 5'b10100);
    tick();
    ctx_req_i = 0; ctx_we_i = 0; cpu_req_i = 1; cpu_addr_i = 32'h310;
    #2;
    check_ctl("ctxwr_cpu_gnt", 5'b11000);
    tick();
    cpu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h44;
    #2;
    check_ctl("ctxwr_silent", 5'b00000);
    tick();
    mem_rdata_i = 32'h55;
    #2;
    check_ctl("ctxwr_cpu_rsp", 5'b00010);
    check("ctxwr_cpu_rdata", cpu_rdata_o, 32'h55);
    tick();

    // Lock: stalled CPU request holds selection even once ctx is starved.
    reset_dut();
    cpu_req_i = 1; cpu_addr_i = 32'h400; cpu_be_i = 4'h3; ctx_addr_i = 32'h900;
    for (int n = 1; n <= 12; n++) begin
      ctx_req_i = (n >= 2);
      mem_gnt_i = (n >= 11);
      if (n == 12) cpu_addr_i = 32'h404;
      #2;
      if (n <= 11) begin
        check_ctl($sformatf("lock_ctl_n%0d", n), (n <= 10) ? 5'b10000 : 5'b11000);
        check($sformatf("lock_addr_n%0d", n), mem_addr_o, 32'h400);
        check($sformatf("lock_be_n%0d", n), 32'(mem_be_o), 32'h3);
      end else begin
        check_ctl("lock_release_ctx", 5'b10100);
        check("lock_release_addr", mem_addr_o, 32'h900);
        check("lock_release_be", 32'(mem_be_o), 32'hF);
      end
      tick();
    end

    // Reset mid-transaction discards outstanding responses.
    reset_dut();
    cpu_req_i = 1; cpu_addr_i = 32'hA00; mem_gnt_i = 1;
    tick();
    tick();
    check("prerst_count", 32'(dut.trk_count), 32'd2);
    mem_rvalid_i = 1;
    rst_n = 0;
    #2;
    check_ctl("midrst_outputs", 5'b00000);
    check("midrst_count", 32'(dut.trk_count), 32'd0);
    tick();
    idle_inputs();
    rst_n = 1;
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD;
    #2;
    check_ctl("stray_rvalid", 5'b00000);
    tick();
    mem_rvalid_i = 0;
    #2;
    check("stray_count", 32'(dut.trk_count), 32'd0);
    tick();

    // Randomized traffic against the reference model.
    reset_dut();
    mq_src.delete(); mq_we.delete();
    m_starve = 0; m_locked = 0; m_lsrc = 0;
    for (int c = 0; c < 3000; c++) begin
      cpu_req_i    = ($urandom_range(0, 7) != 0);
      ctx_req_i    = ($urandom_range(0, 2) == 0);
      cpu_we_i     = 1'($urandom);
      ctx_we_i     = 1'($urandom);
      cpu_be_i     = 4'($urandom);
      cpu_addr_i   = $urandom;
      ctx_addr_i   = $urandom;
      cpu_wdata_i  = $urandom;
      ctx_wdata_i  = $urandom;
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      mem_rvalid_i = (mq_src.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata_i  = $urandom;

      m_req = (cpu_req_i || ctx_req_i) && (mq_src.size() < MAXO);
      if (m_locked)                                         m_sel = m_lsrc;
      else if (ctx_req_i && (m_starve == LIM || !cpu_req_i)) m_sel = 1;
      else                                                  m_sel = 0;
      m_we  = m_sel ? ctx_we_i : cpu_we_i;
      m_cg  = m_req && mem_gnt_i && !m_sel;
      m_xg  = m_req && mem_gnt_i && m_sel;
      m_crv = mem_rvalid_i && (mq_src.size() > 0) && (mq_src[0] == 0);
      m_xrv = mem_rvalid_i && (mq_src.size() > 0) && (mq_src[0] == 1) && (mq_we[0] == 0);

      #2;
      check($sformatf("rnd_ctl_c%0d", c), 32'(ctl5()), 32'({m_req, m_cg, m_xg, m_crv, m_xrv}));
      if (m_req) begin
        check($sformatf("rnd_addr_c%0d", c), mem_addr_o, m_sel ? ctx_addr_i : cpu_addr_i);
        check($sformatf("rnd_be_c%0d", c), 32'(mem_be_o), m_sel ? 32'hF : 32'(cpu_be_i));
        check($sformatf("rnd_we_c%0d", c), 32'(mem_we_o), 32'(m_we));
        check($sformatf("rnd_wdata_c%0d", c), mem_wdata_o, m_sel ? ctx_wdata_i : cpu_wdata_i);
      end
      if (m_crv) check($sformatf("rnd_cpu_rdata_c%0d", c), cpu_rdata_o, mem_rdata_i);
      if (m_xrv) check($sformatf("rnd_ctx_rdata_c%0d", c), ctx_rdata_o, mem_rdata_i);

      if (mem_rvalid_i && mq_src.size() > 0) begin
        void'(mq_src.pop_front());
        void'(mq_we.pop_front());
      end
      if (m_req && mem_gnt_i) begin
        mq_src.push_back(m_sel);
        mq_we.push_back(m_we);
      end
      m_locked = m_req && !mem_gnt_i;
      m_lsrc   = m_sel;
      if (!ctx_req_i || m_xg)  m_starve = 0;
      else if (m_starve < LIM) m_starve++;
      tick();
    end

    idle_inputs();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
